// File: rtl/neuron_layer_sequencer.sv
// Dense-layer sequencer: one signed 8x8 MAC shared across all nodes, weights and bias streamed from ROM.
// Per node: NUM_IN+1 read cycles, one drain cycle, then the result is held until the consumer accepts it.
module neuron_layer_sequencer #(
    parameter int NUM_IN    = 15,
    parameter int NUM_NODES = 32,
    parameter int ACC_W     = 20,
    parameter int ADDR_W    = 9,
    localparam int IDX_W    = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1,
    localparam int K_W      = $clog2(NUM_IN + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [NUM_IN*8-1:0]   act_in,
    output logic                  busy,
    output logic                  w_en,
    output logic [ADDR_W-1:0]     w_addr,
    input  logic [7:0]            w_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [IDX_W-1:0]      out_idx,
    output logic [15:0]           out_data,
    output logic                  done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MAC   = 3'd1,
        S_DRAIN = 3'd2,
        S_EMIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                   state, state_nxt;
    logic [IDX_W-1:0]         node;
    logic [K_W-1:0]           k;
    logic [K_W-1:0]           rd_k;
    logic                     rd_vld;
    logic signed [ACC_W-1:0]  acc;
    logic signed [7:0]        act_q [NUM_IN];

    logic                     last_k;
    logic                     last_node;
    logic                     accept;
    logic signed [7:0]        act_sel;
    logic signed [15:0]       prod;
    logic signed [ACC_W-1:0]  term;
    logic [15:0]              sat_val;

    assign last_k    = (k == K_W'(NUM_IN));
    assign last_node = (node == IDX_W'(NUM_NODES - 1));
    assign accept    = (state == S_EMIT) && out_ready;

    // Activation for the read issued last cycle; the bias slot has no activation.
    always_comb begin
        act_sel = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (rd_k == K_W'(i)) begin
                act_sel = act_q[i];
            end
        end
    end

    assign prod = act_sel * $signed(w_data);

    always_comb begin
        if (rd_k == K_W'(NUM_IN)) begin
            term = {{(ACC_W-8){w_data[7]}}, w_data};
        end else begin
            term = {{(ACC_W-16){prod[15]}}, prod};
        end
    end

    // ReLU, then clamp to the positive 16-bit signed range.
    always_comb begin
        if (acc[ACC_W-1]) begin
            sat_val = 16'h0000;
        end else if (|acc[ACC_W-2:15]) begin
            sat_val = 16'h7FFF;
        end else begin
            sat_val = acc[15:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        w_en      = 1'b0;
        w_addr    = '0;
        out_valid = 1'b0;
        out_idx   = '0;
        out_data  = '0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_MAC;
                end
            end
            S_MAC: begin
                busy   = 1'b1;
                w_en   = 1'b1;
                w_addr = ADDR_W'(node) * ADDR_W'(NUM_IN + 1) + ADDR_W'(k);
                if (last_k) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy      = 1'b1;
                state_nxt = S_EMIT;
            end
            S_EMIT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_idx   = node;
                out_data  = sat_val;
                if (out_ready) begin
                    state_nxt = last_node ? S_DONE : S_MAC;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            node   <= '0;
            k      <= '0;
            rd_k   <= '0;
            rd_vld <= 1'b0;
            acc    <= '0;
            for (int i = 0; i < NUM_IN; i++) begin
                act_q[i] <= '0;
            end
        end else begin
            rd_vld <= (state == S_MAC);
            if (state == S_MAC) begin
                rd_k <= k;
                k    <= last_k ? '0 : k + K_W'(1);
            end

            if (state == S_IDLE && start) begin
                node <= '0;
                k    <= '0;
                acc  <= '0;
                for (int i = 0; i < NUM_IN; i++) begin
                    act_q[i] <= act_in[8*i +: 8];
                end
            end else if (accept && !last_node) begin
                node <= node + IDX_W'(1);
                k    <= '0;
                acc  <= '0;
            end else if (rd_vld) begin
                acc <= acc + term;
            end
        end
    end

endmodule

// File: tb/tb_neuron_layer_sequencer.sv
// Randomized scoreboard bench for neuron_layer_sequencer against an arithmetic reference model.
module tb_neuron_layer_sequencer;

    localparam int NI  = 15;
    localparam int NN  = 32;
    localparam int WPN = NI + 1;
    localparam int AW  = 9;

    logic            clk;
    logic            reset;
    logic            start;
    logic [NI*8-1:0] act_in;
    logic            busy;
    logic            w_en;
    logic [AW-1:0]   w_addr;
    logic [7:0]      w_data;
    logic            out_valid;
    logic            out_ready;
    logic [4:0]      out_idx;
    logic [15:0]     out_data;
    logic            done;

    neuron_layer_sequencer #(.NUM_IN(NI), .NUM_NODES(NN), .ACC_W(20), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .act_in(act_in), .busy(busy),
        .w_en(w_en), .w_addr(w_addr), .w_data(w_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_idx(out_idx), .out_data(out_data), .done(done)
    );

    typedef struct {
        int idx;
        int data;
        int t;
    } exp_t;

    int   rom   [NN*WPN];
    int   act_m [NI];
    exp_t sbq   [$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   exp_done = 0;
    int   done_cnt = 0;
    bit   prev_valid = 0;
    bit   prev_done = 0;

    initial clk = 0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        if (w_en) w_data <= 8'(rom[w_addr]);
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int ref_out(input int n);
        int s = 0;
        for (int i = 0; i < NI; i++) s += act_m[i] * rom[n*WPN + i];
        s += rom[n*WPN + NI];
        if (s < 0) return 0;
        if (s > 32767) return 32767;
        return s;
    endfunction

    // Monitor: every valid cycle is compared to the head of the scoreboard; popped on acceptance.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_beat_queue_size", 1, 0);
                end else begin
                    chk("out_idx", int'(out_idx), sbq[0].idx);
                    chk("out_data", int'(out_data), sbq[0].data);
                    if (!prev_valid && sbq[0].t >= 0)
                        chk("valid_latency", cyc - start_cyc, sbq[0].t);
                    if (out_ready) void'(sbq.pop_front());
                end
            end
            if (done) begin
                chk("done_latency", cyc - start_cyc, exp_done);
                chk("done_single_pulse", int'(prev_done), 0);
                done_cnt++;
            end
            prev_valid = out_valid;
            prev_done  = done;
        end
    end

    task automatic load_acts();
        for (int i = 0; i < NI; i++) act_in[8*i +: 8] = 8'(act_m[i]);
    endtask

    task automatic rand_rom();
        for (int i = 0; i < NN*WPN; i++) rom[i] = int'($urandom_range(0, 255)) - 128;
    endtask

    task automatic rand_acts();
        for (int i = 0; i < NI; i++) act_m[i] = int'($urandom_range(0, 255)) - 128;
    endtask

    task automatic push_layer(input int stall_node);
        for (int n = 0; n < NN; n++) begin
            exp_t e;
            e.idx  = n;
            e.data = ref_out(n);
            e.t    = 17 + 18*n + ((stall_node >= 0 && n > stall_node) ? 5 : 0);
            sbq.push_back(e);
        end
        exp_done = 576 + ((stall_node >= 0) ? 5 : 0);
    endtask

    task automatic do_start();
        load_acts();
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start_cyc = cyc; start = 0;
        // Later changes to act_in must not disturb the latched vector.
        act_in = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        chk("busy_after_start", int'(busy), 1);
    endtask

    task automatic wait_valid_idx(input int idx);
        bit seen = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (out_valid && out_idx == 5'(idx)) begin seen = 1; break; end
        end
        chk("wait_valid_idx_timeout", int'(seen), 1);
    endtask

    task automatic run_layer(input int stall_node);
        bit seen = 0;
        int d0;
        push_layer(stall_node);
        d0 = done_cnt;
        do_start();
        if (stall_node > 0) begin
            wait_valid_idx(stall_node - 1);
            @(posedge clk); #1 out_ready = 0;
            act_in = {$urandom, $urandom, $urandom, $urandom};
            start = 1;
            @(posedge clk); #1 start = 0;
            wait_valid_idx(stall_node);
            repeat (5) @(posedge clk);
            #1 out_ready = 1;
        end
        for (int i = 0; i < 2000; i++) begin
            if (done_cnt != d0) begin seen = 1; break; end
            @(negedge clk);
        end
        chk("done_seen", int'(seen), 1);
        @(negedge clk);
        chk("busy_after_done", int'(busy), 0);
        chk("done_count", done_cnt - d0, 1);
        chk("scoreboard_empty", sbq.size(), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_w_en"}, int'(w_en), 0);
        chk({tag, "_w_addr"}, int'(w_addr), 0);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_out_idx"}, int'(out_idx), 0);
        chk({tag, "_out_data"}, int'(out_data), 0);
        chk({tag, "_done"}, int'(done), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        bit hit;
        reset = 1; start = 0; act_in = '0; out_ready = 1;
        for (int i = 0; i < NN*WPN; i++) rom[i] = 0;
        repeat (3) @(posedge clk);
        #1 chk_reset_outputs("reset");
        start = 1;
        @(posedge clk); #1 start = 0;
        chk("start_in_reset_busy", int'(busy), 0);
        reset = 0;

        // Node0: acts 1, weights 1, bias -1 -> 14.
        rand_rom();
        for (int i = 0; i < NI; i++) act_m[i] = 1;
        for (int i = 0; i < NI; i++) rom[i] = 1;
        rom[NI] = -1;
        run_layer(-1);

        // Node0 saturates high, node1 clamps to zero.
        rand_rom();
        for (int i = 0; i < NI; i++) act_m[i] = 127;
        for (int i = 0; i < NI; i++) begin
            rom[i]       = 127;
            rom[WPN + i] = -128;
        end
        rom[NI]       = 0;
        rom[WPN + NI] = 127;
        run_layer(-1);

        // Full random layers, then one with a 5-cycle stall at node 3 and a stray start.
        rand_rom(); rand_acts();
        run_layer(-1);
        rand_rom();
        for (int i = 0; i < NI; i++) act_m[i] = int'($urandom_range(0, 15)) - 7;
        run_layer(-1);
        rand_rom(); rand_acts();
        run_layer(3);

        // Asynchronous reset in the middle of node 10's MAC phase.
        rand_rom(); rand_acts();
        push_layer(-1);
        d0 = done_cnt;
        do_start();
        hit = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (cyc - start_cyc == 185) begin hit = 1; break; end
        end
        chk("reach_node10", int'(hit), 1);
        chk("node10_mac_w_en", int'(w_en), 1);
        #2 reset = 1;
        #1 chk_reset_outputs("abort");
        chk("abort_pending_results", sbq.size(), NN - 10);
        sbq.delete();
        repeat (2) @(posedge clk);
        #1 reset = 0;
        repeat (3) @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_idle_busy", int'(busy), 0);

        rand_rom(); rand_acts();
        run_layer(-1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
